// File: rtl/sap_ctrl_seq_if.sv
// Bundles the IR opcode input with the sequencer's control outputs (ctrl word, one-hot T-state, halt flag).
// master = sequencer side; slave = the register/datapath side or a bench.
interface sap_ctrl_seq_if;
  logic [3:0]  opcode;
  logic [11:0] ctrl;
  logic [5:0]  t_state;
  logic        halted;

  modport master (
    input  opcode,
    output ctrl,
    output t_state,
    output halted
  );

  modport slave (
    output opcode,
    input  ctrl,
    input  t_state,
    input  halted
  );
endinterface

// File: rtl/sap_ctrl_seq.sv
// SAP-1 controller-sequencer: six-state T1..T6 ring plus microcode decode into the 12-bit active-low-load control word.
// Optional feature macro SINGLE_STEP_EN adds a 'step' qualifier that gates state advance and control output.
module sap_ctrl_seq #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic clk,
  input  logic rst,
`ifdef SINGLE_STEP_EN
  input  logic step,
`endif
  sap_ctrl_seq_if.master bus
);

  // Word layout: {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
  localparam logic [11:0] NOP_W     = 12'h3E3;
  localparam logic [11:0] T1_W      = 12'h5E3;
  localparam logic [11:0] T2_W      = 12'hBE3;
  localparam logic [11:0] T3_W      = 12'h263;
  localparam logic [11:0] MEM_ADR_W = 12'h1A3;
  localparam logic [11:0] LDA_T5_W  = 12'h2C3;
  localparam logic [11:0] LDB_T5_W  = 12'h2E1;
  localparam logic [11:0] ADD_T6_W  = 12'h3C7;
  localparam logic [11:0] SUB_T6_W  = 12'h3CF;
  localparam logic [11:0] OUT_T4_W  = 12'h3F2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        adv;
  logic [11:0] word;
  logic [5:0]  t_oh;
  logic        halt_o;

`ifdef SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word    = NOP_W;
    t_oh    = 6'b000000;
    halt_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (adv) state_d = S_T1;
      end
      S_T1: begin
        word = T1_W;
        t_oh = 6'b000001;
        if (adv) state_d = S_T2;
      end
      S_T2: begin
        word = T2_W;
        t_oh = 6'b000010;
        if (adv) state_d = S_T3;
      end
      S_T3: begin
        word = T3_W;
        t_oh = 6'b000100;
        if (adv) state_d = S_T4;
      end
      S_T4: begin
        t_oh = 6'b001000;
        if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          word = MEM_ADR_W;
        end else if (bus.opcode == OP_OUT) begin
          word = OUT_T4_W;
        end
        // HLT leaves T4 straight into HALT instead of finishing the instruction
        if (adv) state_d = (bus.opcode == OP_HLT) ? S_HALT : S_T5;
      end
      S_T5: begin
        t_oh = 6'b010000;
        if (bus.opcode == OP_LDA) begin
          word = LDA_T5_W;
        end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          word = LDB_T5_W;
        end
        if (adv) state_d = S_T6;
      end
      S_T6: begin
        t_oh = 6'b100000;
        if (bus.opcode == OP_ADD) begin
          word = ADD_T6_W;
        end else if (bus.opcode == OP_SUB) begin
          word = SUB_T6_W;
        end
        if (adv) state_d = S_T1;
      end
      S_HALT: begin
        halt_o = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // While waiting for a step, hold every line inactive so no register loads twice
  assign bus.ctrl    = adv ? word : NOP_W;
  assign bus.t_state = t_oh;
  assign bus.halted  = halt_o;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Directed bench for sap_ctrl_seq: driver pushes the expected per-cycle outputs, a negedge monitor pops and compares.
module tb_sap_ctrl_seq;
  logic clk;
  logic rst;
`ifdef SINGLE_STEP_EN
  logic step;
`endif

  sap_ctrl_seq_if bus ();

  sap_ctrl_seq dut (
    .clk (clk),
    .rst (rst),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .bus (bus.master)
  );

  typedef struct packed {
    logic [11:0] c;
    logic [5:0]  t;
    logic        h;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;

  localparam logic [11:0] NOP = 12'h3E3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: the inputs set here take effect combinationally now and at the next edge for rst/step
  task automatic cyc(input logic r, input logic s, input logic [3:0] op,
                     input logic [11:0] c, input logic [5:0] t, input logic h);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
`ifdef SINGLE_STEP_EN
    step = s;
`else
    if (s !== 1'b1) $display("note: step=0 requested in free-running build");
`endif
    bus.opcode = op;
    e.c = c;
    e.t = t;
    e.h = h;
    exp_q.push_back(e);
  endtask

  task automatic fetch();
    cyc(1'b0, 1'b1, 4'h0, 12'h5E3, 6'h01, 1'b0);
    cyc(1'b0, 1'b1, 4'h0, 12'hBE3, 6'h02, 1'b0);
    cyc(1'b0, 1'b1, 4'h0, 12'h263, 6'h04, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   drv;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc_no++;
      checks++;
      if (bus.ctrl !== e.c || bus.t_state !== e.t || bus.halted !== e.h) begin
        failures++;
        $display("FAIL outputs cyc=%0d got ctrl=%h t=%h halt=%b want ctrl=%h t=%h halt=%b",
                 cyc_no, bus.ctrl, bus.t_state, bus.halted, e.c, e.t, e.h);
      end
      checks++;
      if (bus.ctrl[7] !== 1'b1 && bus.t_state !== 6'h04) begin
        failures++;
        $display("FAIL ir_reload cyc=%0d got Li_n=%b t=%h want Li_n=1 outside T3",
                 cyc_no, bus.ctrl[7], bus.t_state);
      end
      drv = int'(bus.ctrl[10]) + int'(!bus.ctrl[8]) + int'(!bus.ctrl[6])
          + int'(bus.ctrl[4]) + int'(bus.ctrl[2]);
      checks++;
      if (drv > 1) begin
        failures++;
        $display("FAIL bus_contention cyc=%0d got %0d drivers ctrl=%h want <=1", cyc_no, drv, bus.ctrl);
      end
    end
  end

  initial begin
    rst = 1'b1;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    bus.opcode = 4'h0;

    // Reset for two edges, then fetch
    cyc(1'b1, 1'b1, 4'h0, NOP, 6'h00, 1'b0);
    cyc(1'b0, 1'b1, 4'h0, NOP, 6'h00, 1'b0);
    fetch();
    // LDA
    cyc(1'b0, 1'b1, 4'h0, 12'h1A3, 6'h08, 1'b0);
    cyc(1'b0, 1'b1, 4'h0, 12'h2C3, 6'h10, 1'b0);
    cyc(1'b0, 1'b1, 4'h0, NOP,     6'h20, 1'b0);
    // ADD then SUB back to back
    fetch();
    cyc(1'b0, 1'b1, 4'h1, 12'h1A3, 6'h08, 1'b0);
    cyc(1'b0, 1'b1, 4'h1, 12'h2E1, 6'h10, 1'b0);
    cyc(1'b0, 1'b1, 4'h1, 12'h3C7, 6'h20, 1'b0);
    fetch();
    cyc(1'b0, 1'b1, 4'h2, 12'h1A3, 6'h08, 1'b0);
    cyc(1'b0, 1'b1, 4'h2, 12'h2E1, 6'h10, 1'b0);
    cyc(1'b0, 1'b1, 4'h2, 12'h3CF, 6'h20, 1'b0);
    // OUT
    fetch();
    cyc(1'b0, 1'b1, 4'hE, 12'h3F2, 6'h08, 1'b0);
    cyc(1'b0, 1'b1, 4'hE, NOP,     6'h10, 1'b0);
    cyc(1'b0, 1'b1, 4'hE, NOP,     6'h20, 1'b0);
    // Unlisted opcode is a NOP instruction
    fetch();
    cyc(1'b0, 1'b1, 4'h7, NOP, 6'h08, 1'b0);
    cyc(1'b0, 1'b1, 4'h7, NOP, 6'h10, 1'b0);
    cyc(1'b0, 1'b1, 4'h7, NOP, 6'h20, 1'b0);
    // Opcode switched mid-execute takes effect at once
    fetch();
    cyc(1'b0, 1'b1, 4'h0, 12'h1A3, 6'h08, 1'b0);
    cyc(1'b0, 1'b1, 4'h2, 12'h2E1, 6'h10, 1'b0);
    cyc(1'b0, 1'b1, 4'h2, 12'h3CF, 6'h20, 1'b0);
    // Reset during T5 of ADD aborts into IDLE
    fetch();
    cyc(1'b0, 1'b1, 4'h1, 12'h1A3, 6'h08, 1'b0);
    cyc(1'b1, 1'b1, 4'h1, 12'h2E1, 6'h10, 1'b0);
    cyc(1'b0, 1'b1, 4'h1, NOP,     6'h00, 1'b0);
    // HLT
    fetch();
    cyc(1'b0, 1'b1, 4'hF, NOP, 6'h08, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 4'hF, NOP, 6'h00, 1'b1);
    end
    cyc(1'b1, 1'b1, 4'hF, NOP, 6'h00, 1'b1);
    cyc(1'b0, 1'b1, 4'h0, NOP, 6'h00, 1'b0);
    cyc(1'b0, 1'b1, 4'h0, 12'h5E3, 6'h01, 1'b0);
`ifdef SINGLE_STEP_EN
    begin
      logic [11:0] w [6];
      logic [5:0]  t;
      w[0] = 12'h5E3; w[1] = 12'hBE3; w[2] = 12'h263;
      w[3] = 12'h3F2; w[4] = NOP;     w[5] = NOP;
      // Now in T2, step low, reset requested
      cyc(1'b1, 1'b0, 4'hE, NOP, 6'h02, 1'b0);
      cyc(1'b0, 1'b0, 4'hE, NOP, 6'h00, 1'b0);
      cyc(1'b0, 1'b0, 4'hE, NOP, 6'h00, 1'b0);
      cyc(1'b0, 1'b0, 4'hE, NOP, 6'h00, 1'b0);
      cyc(1'b0, 1'b1, 4'hE, NOP, 6'h00, 1'b0);
      t = 6'h01;
      for (int k = 0; k < 6; k++) begin
        for (int j = 0; j < 3; j++) begin
          cyc(1'b0, 1'b0, 4'hE, NOP, t, 1'b0);
        end
        cyc(1'b0, 1'b1, 4'hE, w[k], t, 1'b0);
        t = t << 1;
      end
      cyc(1'b0, 1'b1, 4'hE, 12'h5E3, 6'h01, 1'b0);
    end
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
